// File: rtl/pipe_delay_ring.sv
// Fixed-latency ring delay buffer for ADC sample words: DOUT follows DIN by PDEPTH
// write cycles, with sticky overflow/underflow/depth-mismatch status flags.
module pipe_delay_ring #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PIP_RST,
  input  logic              WE,
  input  logic              RE,
  input  logic [ADDR_W-1:0] PDEPTH,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] DOUT,
  output logic              DOUT_VLD,
  output logic [ADDR_W:0]   FILL,
  output logic              OVFL,
  output logic              UNDFL,
  output logic              DEPTH_ERR
);

  localparam logic [ADDR_W:0]   FILL_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   FILL_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   FILL_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_r [2**ADDR_W];
  logic [ADDR_W-1:0] wptr_r;
  logic [ADDR_W-1:0] rptr_r;
  logic              wr_ok_s;
  logic              rd_ok_s;
  logic              depth_mis_s;

  // Acceptance decisions, all taken from the pre-edge occupancy.
  always_comb begin
    wr_ok_s     = 1'b0;
    rd_ok_s     = 1'b0;
    depth_mis_s = 1'b0;
    // A full ring still takes a write when a read frees a slot in the same cycle.
    wr_ok_s     = WE & ((FILL != FILL_FULL) | RE);
    rd_ok_s     = RE & (FILL != FILL_ZERO);
    depth_mis_s = (FILL != {1'b0, PDEPTH});
  end

  // Ring storage write port; kept reset-free so it maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (wr_ok_s && !PIP_RST) begin
      mem_r[wptr_r] <= DIN;
    end
  end

  // Pointers, occupancy, registered read data and sticky status flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr_r    <= PTR_ZERO;
      rptr_r    <= PTR_ZERO;
      FILL      <= FILL_ZERO;
      DOUT      <= {DATA_W{1'b0}};
      DOUT_VLD  <= 1'b0;
      OVFL      <= 1'b0;
      UNDFL     <= 1'b0;
      DEPTH_ERR <= 1'b0;
    end else if (PIP_RST) begin
      wptr_r    <= PTR_ZERO;
      rptr_r    <= PTR_ZERO;
      FILL      <= FILL_ZERO;
      DOUT      <= {DATA_W{1'b0}};
      DOUT_VLD  <= 1'b0;
      OVFL      <= 1'b0;
      UNDFL     <= 1'b0;
      DEPTH_ERR <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (rd_ok_s) begin
        rptr_r <= rptr_r + PTR_ONE;
        // Read-first: the word at rptr is taken before any same-cycle write lands.
        DOUT   <= mem_r[rptr_r];
      end
      DOUT_VLD <= rd_ok_s;
      case ({wr_ok_s, rd_ok_s})
        2'b10:   FILL <= FILL + FILL_ONE;
        2'b01:   FILL <= FILL - FILL_ONE;
        default: FILL <= FILL;
      endcase
      OVFL      <= OVFL | (WE & ~wr_ok_s);
      UNDFL     <= UNDFL | (RE & ~rd_ok_s);
      DEPTH_ERR <= DEPTH_ERR | (rd_ok_s & depth_mis_s);
    end
  end

endmodule

// File: tb/tb_pipe_delay_ring.sv
// Randomised bench for pipe_delay_ring; a queue-based FIFO model supplies every expectation.
module tb_pipe_delay_ring;

  logic        CLK;
  logic        RST;
  logic        PIP_RST;
  logic        WE;
  logic        RE;
  logic [8:0]  PDEPTH;
  logic [15:0] DIN;
  logic [15:0] DOUT;
  logic        DOUT_VLD;
  logic [9:0]  FILL;
  logic        OVFL;
  logic        UNDFL;
  logic        DEPTH_ERR;

  int errors = 0;
  int checks = 0;

  logic [15:0] q[$];
  logic [15:0] m_dout;
  logic        m_vld;
  logic        m_ovfl;
  logic        m_undfl;
  logic        m_derr;

  pipe_delay_ring #(.DATA_W(16), .ADDR_W(9)) dut (
    .CLK(CLK), .RST(RST), .PIP_RST(PIP_RST), .WE(WE), .RE(RE), .PDEPTH(PDEPTH),
    .DIN(DIN), .DOUT(DOUT), .DOUT_VLD(DOUT_VLD), .FILL(FILL), .OVFL(OVFL),
    .UNDFL(UNDFL), .DEPTH_ERR(DEPTH_ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic model_clear();
    q.delete();
    m_dout  = 16'h0000;
    m_vld   = 1'b0;
    m_ovfl  = 1'b0;
    m_undfl = 1'b0;
    m_derr  = 1'b0;
  endtask

  // Drive one cycle, advance the FIFO model across the edge, settle 1 time unit after it.
  task automatic step(input logic we, input logic re, input logic pip, input logic [15:0] din);
    bit full, wr_ok, rd_ok;
    WE = we; RE = re; PIP_RST = pip; DIN = din;
    @(posedge CLK);
    if (pip) begin
      model_clear();
    end else begin
      full  = (q.size() == 512);
      wr_ok = we && (!full || re);
      rd_ok = re && (q.size() != 0);
      if (we && !wr_ok) m_ovfl = 1'b1;
      if (re && !rd_ok) m_undfl = 1'b1;
      if (rd_ok && q.size() != int'(PDEPTH)) m_derr = 1'b1;
      if (rd_ok) begin
        m_dout = q.pop_front();
        m_vld  = 1'b1;
      end else begin
        m_vld = 1'b0;
      end
      if (wr_ok) q.push_back(din);
    end
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; PIP_RST = 1'b0; WE = 1'b0; RE = 1'b0; DIN = 16'h0000; PDEPTH = 9'd37;
    model_clear();
    #12;
    checks++;
    if (FILL !== 10'd0 || DOUT !== 16'h0000 || DOUT_VLD !== 1'b0 || {OVFL, UNDFL, DEPTH_ERR} !== 3'b000) begin
      errors++;
      $display("FAIL reset_state: fill=%0d dout=%h vld=%b flags=%b%b%b, want all 0", FILL, DOUT, DOUT_VLD, OVFL, UNDFL, DEPTH_ERR);
    end
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 37; i++) step(1'b1, 1'b0, 1'b0, 16'(16'h100 + i));
    step(1'b1, 1'b1, 1'b0, 16'hBEEF);
    checks++;
    if (FILL !== 10'd37 || DOUT_VLD !== 1'b1 || DOUT !== m_dout || DEPTH_ERR !== m_derr) begin
      errors++;
      $display("FAIL pre_reset_run: fill=%0d vld=%b dout=%h derr=%b, want 37 1 %h %b", FILL, DOUT_VLD, DOUT, DEPTH_ERR, m_dout, m_derr);
    end
    #1 RST = 1'b1;
    model_clear();
    #1;
    checks++;
    if (FILL !== 10'd0 || DOUT !== 16'h0000 || DOUT_VLD !== 1'b0 || {OVFL, UNDFL, DEPTH_ERR} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: fill=%0d dout=%h vld=%b flags=%b%b%b, want all 0", FILL, DOUT, DOUT_VLD, OVFL, UNDFL, DEPTH_ERR);
    end
    #2 RST = 1'b0;
    step(1'b1, 1'b0, 1'b0, 16'h1111);
    step(1'b1, 1'b0, 1'b0, 16'h2222);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0000);
      checks++;
      if (DOUT !== m_dout || DOUT_VLD !== 1'b1 || FILL !== 10'(q.size())) begin
        errors++;
        $display("FAIL post_reset_read%0d: dout=%h vld=%b fill=%0d, want %h 1 %0d", i, DOUT, DOUT_VLD, FILL, m_dout, q.size());
      end
    end
  endtask

  task automatic test_pipeline();
    bit seen_first = 1'b0;
    PDEPTH = 9'd20;
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    for (int i = 1; i <= 20; i++) step(1'b1, 1'b0, 1'b0, 16'(i));
    for (int i = 21; i <= 60; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'(i));
      checks++;
      if (FILL !== 10'd20 || DOUT !== m_dout || DOUT_VLD !== 1'b1 || {OVFL, UNDFL, DEPTH_ERR} !== 3'b000) begin
        errors++;
        $display("FAIL pipeline cyc %0d: fill=%0d dout=%h vld=%b flags=%b%b%b, want 20 %h 1 000", i, FILL, DOUT, DOUT_VLD, OVFL, UNDFL, DEPTH_ERR, m_dout);
      end
      if (!seen_first) begin
        seen_first = 1'b1;
        checks++;
        if (DOUT !== 16'd1) begin
          errors++;
          $display("FAIL pipeline_first: dout=%0d, want 1", DOUT);
        end
      end
    end
  endtask

  task automatic test_overflow();
    PDEPTH = 9'd20;
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 512; i++) step(1'b1, 1'b0, 1'b0, 16'($urandom));
    checks++;
    if (FILL !== 10'd512 || OVFL !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: fill=%0d ovfl=%b, want 512 0", FILL, OVFL);
    end
    step(1'b1, 1'b0, 1'b0, 16'hDEAD);
    checks++;
    if (FILL !== 10'd512 || OVFL !== 1'b1 || UNDFL !== 1'b0) begin
      errors++;
      $display("FAIL overflow: fill=%0d ovfl=%b undfl=%b, want 512 1 0", FILL, OVFL, UNDFL);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'($urandom));
      checks++;
      if (FILL !== 10'd512 || DOUT !== m_dout || DOUT_VLD !== 1'b1 || OVFL !== 1'b1 || UNDFL !== 1'b0 || DEPTH_ERR !== m_derr) begin
        errors++;
        $display("FAIL full_wr_rd%0d: fill=%0d dout=%h vld=%b ovfl=%b undfl=%b derr=%b, want 512 %h 1 1 0 %b", i, FILL, DOUT, DOUT_VLD, OVFL, UNDFL, DEPTH_ERR, m_dout, m_derr);
      end
    end
  endtask

  task automatic test_underflow();
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    step(1'b1, 1'b1, 1'b0, 16'h5A5A);
    checks++;
    if (UNDFL !== 1'b1 || DOUT_VLD !== 1'b0 || FILL !== 10'd1 || OVFL !== 1'b0) begin
      errors++;
      $display("FAIL underflow: undfl=%b vld=%b fill=%0d ovfl=%b, want 1 0 1 0", UNDFL, DOUT_VLD, FILL, OVFL);
    end
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    checks++;
    if (DOUT !== 16'h5A5A || DOUT_VLD !== 1'b1 || FILL !== 10'd0 || UNDFL !== 1'b1) begin
      errors++;
      $display("FAIL no_bypass_read: dout=%h vld=%b fill=%0d undfl=%b, want 5a5a 1 0 1", DOUT, DOUT_VLD, FILL, UNDFL);
    end
  endtask

  task automatic test_depth_err();
    PDEPTH = 9'd20;
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 19; i++) step(1'b1, 1'b0, 1'b0, 16'(i + 7));
    step(1'b1, 1'b1, 1'b0, 16'h0042);
    checks++;
    if (DEPTH_ERR !== 1'b1 || DOUT !== 16'd7 || DOUT_VLD !== 1'b1) begin
      errors++;
      $display("FAIL depth_err_set: derr=%b dout=%0d vld=%b, want 1 7 1", DEPTH_ERR, DOUT, DOUT_VLD);
    end
    step(1'b1, 1'b1, 1'b1, 16'h0043);
    checks++;
    if (DEPTH_ERR !== 1'b0 || FILL !== 10'd0 || DOUT_VLD !== 1'b0 || DOUT !== 16'h0000) begin
      errors++;
      $display("FAIL depth_err_clear: derr=%b fill=%0d vld=%b dout=%h, want 0 0 0 0000", DEPTH_ERR, FILL, DOUT_VLD, DOUT);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] hist[$];
    logic [15:0] d;
    int bad = 0;
    PDEPTH = 9'd500;
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 500; i++) begin
      d = 16'($urandom);
      hist.push_back(d);
      step(1'b1, 1'b0, 1'b0, d);
    end
    for (int t = 0; t < 2000; t++) begin
      d = 16'($urandom);
      hist.push_back(d);
      step(1'b1, 1'b1, 1'b0, d);
      checks++;
      // hist holds one entry per write cycle; the read this cycle returns the word written 500 writes ago.
      if (DOUT !== hist[t] || DOUT !== m_dout || DOUT_VLD !== 1'b1 || FILL !== 10'd500 || {OVFL, UNDFL, DEPTH_ERR} !== 3'b000) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL wrap t=%0d: dout=%h vld=%b fill=%0d flags=%b%b%b, want %h 1 500 000", t, DOUT, DOUT_VLD, FILL, OVFL, UNDFL, DEPTH_ERR, hist[t]);
      end
    end
  endtask

  task automatic test_random();
    int bad = 0;
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 199) == 0) PDEPTH = 9'($urandom_range(0, 40));
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
           1'($urandom_range(0, 299) == 0), 16'($urandom));
      checks++;
      if (FILL !== 10'(q.size()) || DOUT !== m_dout || DOUT_VLD !== m_vld || OVFL !== m_ovfl || UNDFL !== m_undfl || DEPTH_ERR !== m_derr) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL random t=%0d: fill=%0d/%0d dout=%h/%h vld=%b/%b flags=%b%b%b/%b%b%b", t, FILL, q.size(), DOUT, m_dout, DOUT_VLD, m_vld, OVFL, UNDFL, DEPTH_ERR, m_ovfl, m_undfl, m_derr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pipeline();
    test_overflow();
    test_underflow();
    test_depth_err();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
